// File: rtl/spike_time_decoder.sv
// Race-logic decoder: timestamps the first spike edge in each gamma window (optional SPIKE_GLITCH_FILTER_EN qualifies edges over 2 cycles).
// Latency: result valid at window start + G, or one cycle after an early restart.
// Backpressure: single-entry valid/ready slot; a result that finds the slot held is dropped and sets sticky overrun.
module spike_time_decoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          gamma_start,
    input  logic          spike,
    output logic [TW-1:0] t_value,
    output logic          t_none,
    output logic          t_valid,
    input  logic          t_ready,
    output logic          overrun,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [TW-1:0] G_VAL = TW'(GAMMA_CYCLE_WIDTH);
    localparam logic [TW-1:0] LAST  = TW'(GAMMA_CYCLE_WIDTH - 1);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] cap;
    logic          hit;
    logic          spike_d;

    logic          edge_now;
    logic          in_count;
    logic          at_last;
    logic          closing;
    logic          own_cycle;
    logic          slot_open;
    logic          old_hit;
    logic [TW-1:0] old_cap;

    assign edge_now  = spike & ~spike_d;
    assign in_count  = (state == COUNT);
    assign at_last   = in_count && (tcnt == LAST);
    assign closing   = in_count && (at_last || gamma_start);
    // An early restart hands the current cycle to the new window; a natural close keeps it.
    assign own_cycle = in_count && (at_last || !gamma_start);
    assign slot_open = !t_valid || t_ready;

`ifdef SPIKE_GLITCH_FILTER_EN
    logic          pend;
    logic [TW-1:0] pend_t;
    logic          confirm;
    logic          arm;

    // An edge is only recorded once spike is seen still high one cycle later.
    assign confirm = own_cycle && pend && spike && !hit;
    assign arm     = own_cycle && edge_now && !hit && !at_last;
    assign old_hit = hit || confirm;
    assign old_cap = hit ? cap : pend_t;
`else
    assign old_hit = hit || (own_cycle && edge_now);
    assign old_cap = hit ? cap : tcnt;
`endif

    always_ff @(posedge aclk) begin
        if (!grst) begin
            state   <= IDLE;
            tcnt    <= '0;
            cap     <= '0;
            hit     <= 1'b0;
            spike_d <= 1'b0;
            t_value <= '0;
            t_none  <= 1'b0;
            t_valid <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
`ifdef SPIKE_GLITCH_FILTER_EN
            pend    <= 1'b0;
            pend_t  <= '0;
`endif
        end else begin
            spike_d <= spike;

            if (closing) begin
                if (slot_open) begin
                    t_valid <= 1'b1;
                    t_value <= old_hit ? old_cap : G_VAL;
                    t_none  <= !old_hit;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (t_valid && t_ready) begin
                t_valid <= 1'b0;
            end

            if (gamma_start) begin
                // This cycle is time 0 of the new window, so the next one is time 1.
                state <= COUNT;
                busy  <= 1'b1;
                tcnt  <= TW'(1);
                cap   <= '0;
`ifdef SPIKE_GLITCH_FILTER_EN
                hit    <= 1'b0;
                pend   <= edge_now;
                pend_t <= '0;
`else
                hit   <= edge_now;
`endif
            end else if (in_count) begin
                if (at_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    hit   <= 1'b0;
`ifdef SPIKE_GLITCH_FILTER_EN
                    pend  <= 1'b0;
`endif
                end else begin
                    tcnt <= tcnt + TW'(1);
                    hit  <= old_hit;
                    cap  <= old_cap;
`ifdef SPIKE_GLITCH_FILTER_EN
                    pend   <= arm;
                    pend_t <= tcnt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_time_decoder.sv
// Bench for spike_time_decoder: directed scenarios plus random traces scored against a per-window reference model.
module tb_spike_time_decoder;

    localparam int G    = 16;
    localparam int TW   = $clog2(G) + 1;
    localparam int MAXN = 512;

    logic          aclk = 1'b0;
    logic          grst = 1'b0;
    logic          gamma_start = 1'b0;
    logic          spike = 1'b0;
    logic          t_ready = 1'b0;
    logic [TW-1:0] t_value;
    logic          t_none;
    logic          t_valid;
    logic          overrun;
    logic          busy;

    spike_time_decoder #(.GAMMA_CYCLE_WIDTH(G)) dut (
        .aclk        (aclk),
        .grst        (grst),
        .gamma_start (gamma_start),
        .spike       (spike),
        .t_value     (t_value),
        .t_none      (t_none),
        .t_valid     (t_valid),
        .t_ready     (t_ready),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus per trace cycle, and outputs observed just after that cycle's edge.
    bit            gs [MAXN];
    bit            sp [MAXN];
    bit            rdy[MAXN];
    bit            rs [MAXN];
    logic          ov_valid[MAXN];
    logic          ov_none [MAXN];
    logic          ov_ovr  [MAXN];
    logic          ov_busy [MAXN];
    logic [TW-1:0] ov_value[MAXN];

    bit            e_valid[MAXN];
    bit            e_none [MAXN];
    bit            e_ovr  [MAXN];
    bit            e_busy [MAXN];
    int            e_value[MAXN];

    task automatic clear(input bit ready_level);
        for (int i = 0; i < MAXN; i++) begin
            gs[i] = 1'b0; sp[i] = 1'b0; rdy[i] = ready_level; rs[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        grst = 1'b0; gamma_start = 1'b0; spike = 1'b0; t_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1 grst = 1'b1;
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            grst = !rs[i]; gamma_start = gs[i]; spike = sp[i]; t_ready = rdy[i];
            @(posedge aclk);
            #1;
            ov_valid[i] = t_valid; ov_none[i] = t_none; ov_ovr[i] = overrun;
            ov_busy[i] = busy; ov_value[i] = t_value;
        end
        grst = 1'b1; gamma_start = 1'b0; spike = 1'b0; t_ready = 1'b0;
    endtask

    // Reference: every gamma_start opens a window; it closes at start+G-1, or on the
    // cycle of an earlier restart (which then belongs to the new window).
    task automatic model(input int n);
        bit cm[MAXN];
        int cv[MAXN];
        int c, last, found;
        bit prev, v, nn, ov;
        int val;
        for (int i = 0; i < MAXN; i++) begin
            cm[i] = 1'b0; cv[i] = 0; e_busy[i] = 1'b0;
        end
        for (int s = 0; s < n; s++) begin
            if (gs[s]) begin
                c = s + G - 1;
                last = c;
                for (int j = s + 1; j < s + G - 1; j++) begin
                    if (gs[j] && c == s + G - 1) begin
                        c = j;
                        last = j - 1;
                    end
                end
                found = -1;
                for (int t = s; t <= last; t++) begin
                    prev = (t > 0) ? sp[t-1] : 1'b0;
`ifdef SPIKE_GLITCH_FILTER_EN
                    if (found < 0 && sp[t] && !prev && t + 1 <= last && sp[t+1]) found = t - s;
`else
                    if (found < 0 && sp[t] && !prev) found = t - s;
`endif
                end
                for (int i = s; i < c && i < n; i++) e_busy[i] = 1'b1;
                if (c < n) begin
                    cm[c] = 1'b1;
                    cv[c] = (found < 0) ? G : found;
                end
            end
        end
        v = 1'b0; nn = 1'b0; ov = 1'b0; val = 0;
        for (int i = 0; i < n; i++) begin
            if (cm[i]) begin
                if (!v || rdy[i]) begin
                    v = 1'b1; val = cv[i]; nn = (cv[i] == G);
                end else begin
                    ov = 1'b1;
                end
            end else if (v && rdy[i]) begin
                v = 1'b0;
            end
            e_valid[i] = v; e_value[i] = val; e_none[i] = nn; e_ovr[i] = ov;
        end
    endtask

    task automatic test_reset();
        grst = 1'b0; gamma_start = 1'b1; spike = 1'b1; t_ready = 1'b1;
        @(posedge aclk);
        #1;
        n_cmp++;
        if ({t_valid, t_none, overrun, busy, t_value} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v%b n%b o%b b%b val%0d want all 0", t_valid, t_none, overrun, busy, t_value);
        end
        do_reset();
        @(posedge aclk);
        #1;
        n_cmp++;
        if ({t_valid, t_none, overrun, busy, t_value} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got v%b n%b o%b b%b val%0d want all 0", t_valid, t_none, overrun, busy, t_value);
        end
    endtask

    task automatic test_basic();
        do_reset(); clear(1'b1);
        gs[10] = 1'b1;
        for (int i = 15; i < 23; i++) sp[i] = 1'b1;
        play(40);
        n_cmp++;
        if (ov_valid[25] !== 1'b1 || ov_value[25] !== TW'(5) || ov_none[25] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_commit: got v%b val%0d n%b want v1 val5 n0", ov_valid[25], ov_value[25], ov_none[25]);
        end
        n_cmp++;
        if ({ov_valid[24], ov_valid[26]} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_one_cycle: got before/after %b%b want 00", ov_valid[24], ov_valid[26]);
        end
        n_cmp++;
        if ({ov_busy[9], ov_busy[10], ov_busy[24], ov_busy[25]} !== 4'b0110) begin
            n_bad++;
            $display("FAIL basic_busy: got %b%b%b%b want 0110", ov_busy[9], ov_busy[10], ov_busy[24], ov_busy[25]);
        end
    endtask

    task automatic test_no_spike();
        do_reset(); clear(1'b1);
        gs[5] = 1'b1;
        play(25);
        n_cmp++;
        if (ov_valid[19] !== 1'b0 || ov_valid[20] !== 1'b1 || ov_value[20] !== TW'(G) || ov_none[20] !== 1'b1) begin
            n_bad++;
            $display("FAIL no_spike: got v%b%b val%0d n%b want v01 val%0d n1", ov_valid[19], ov_valid[20], ov_value[20], ov_none[20], G);
        end
    endtask

    task automatic test_first_edge();
        do_reset(); clear(1'b1);
        gs[3] = 1'b1;
        sp[6] = 1'b1; sp[7] = 1'b1; sp[12] = 1'b1; sp[13] = 1'b1;
        play(25);
        n_cmp++;
        if (ov_valid[18] !== 1'b1 || ov_value[18] !== TW'(3) || ov_none[18] !== 1'b0) begin
            n_bad++;
            $display("FAIL first_edge: got v%b val%0d n%b want v1 val3 n0", ov_valid[18], ov_value[18], ov_none[18]);
        end
    endtask

    task automatic test_overrun();
        do_reset(); clear(1'b0);
        gs[2] = 1'b1;  sp[4] = 1'b1;  sp[5] = 1'b1;
        gs[18] = 1'b1; sp[25] = 1'b1; sp[26] = 1'b1;
        rdy[40] = 1'b1;
        play(45);
        n_cmp++;
        if (ov_valid[17] !== 1'b1 || ov_value[17] !== TW'(2) || ov_ovr[17] !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_first: got v%b val%0d o%b want v1 val2 o0", ov_valid[17], ov_value[17], ov_ovr[17]);
        end
        n_cmp++;
        if (ov_ovr[32] !== 1'b0 || ov_ovr[33] !== 1'b1 || ov_value[33] !== TW'(2)) begin
            n_bad++;
            $display("FAIL overrun_drop: got o%b%b val%0d want o01 val2", ov_ovr[32], ov_ovr[33], ov_value[33]);
        end
        n_cmp++;
        if (ov_valid[39] !== 1'b1 || ov_value[39] !== TW'(2) || ov_valid[40] !== 1'b0 || ov_ovr[44] !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_drain: got v%b val%0d v%b o%b want v1 val2 v0 o1", ov_valid[39], ov_value[39], ov_valid[40], ov_ovr[44]);
        end
    endtask

    task automatic test_early_restart();
        do_reset(); clear(1'b1);
        gs[2] = 1'b1; gs[8] = 1'b1;
        sp[9] = 1'b1; sp[10] = 1'b1;
        play(30);
        n_cmp++;
        if (ov_valid[7] !== 1'b0 || ov_valid[8] !== 1'b1 || ov_value[8] !== TW'(G) || ov_none[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_first: got v%b%b val%0d n%b want v01 val%0d n1", ov_valid[7], ov_valid[8], ov_value[8], ov_none[8], G);
        end
        n_cmp++;
        if (ov_valid[23] !== 1'b1 || ov_value[23] !== TW'(1) || ov_none[23] !== 1'b0 || ov_busy[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_second: got v%b val%0d n%b b%b want v1 val1 n0 b1", ov_valid[23], ov_value[23], ov_none[23], ov_busy[8]);
        end
    endtask

    task automatic test_glitch();
        int want;
`ifdef SPIKE_GLITCH_FILTER_EN
        want = 8;
`else
        want = 4;
`endif
        do_reset(); clear(1'b1);
        gs[2] = 1'b1;
        sp[6] = 1'b1; sp[10] = 1'b1; sp[11] = 1'b1;
        play(22);
        n_cmp++;
        if (ov_valid[17] !== 1'b1 || ov_value[17] !== TW'(want)) begin
            n_bad++;
            $display("FAIL glitch: got v%b val%0d want v1 val%0d", ov_valid[17], ov_value[17], want);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset(); clear(1'b1);
        gs[2] = 1'b1; sp[5] = 1'b1; sp[6] = 1'b1;
        rs[9] = 1'b1;
        play(40);
        n_cmp++;
        if (ov_busy[8] !== 1'b1 || {ov_valid[9], ov_none[9], ov_ovr[9], ov_busy[9], ov_value[9]} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got busy_before %b, after v%b n%b o%b b%b val%0d want 1 then all 0",
                     ov_busy[8], ov_valid[9], ov_none[9], ov_ovr[9], ov_busy[9], ov_value[9]);
        end
        seen = 1'b0;
        for (int i = 9; i < 40; i++) if (ov_valid[i] !== 1'b0 || ov_busy[i] !== 1'b0) seen = 1'b1;
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_mid_no_commit: got activity after reset=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(); clear(1'b1);
        gs[2] = 1'b1; gs[17] = 1'b1;
        sp[7] = 1'b1; sp[8] = 1'b1; sp[27] = 1'b1; sp[28] = 1'b1;
        play(40);
        n_cmp++;
        if (ov_valid[17] !== 1'b1 || ov_value[17] !== TW'(5) || ov_valid[18] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_first: got v%b val%0d next_v%b want v1 val5 next_v0", ov_valid[17], ov_value[17], ov_valid[18]);
        end
        n_cmp++;
        if (ov_busy[17] !== 1'b1 || ov_busy[18] !== 1'b1 || ov_valid[32] !== 1'b1 || ov_value[32] !== TW'(10)) begin
            n_bad++;
            $display("FAIL b2b_second: got b%b%b v%b val%0d want b11 v1 val10", ov_busy[17], ov_busy[18], ov_valid[32], ov_value[32]);
        end
    endtask

    task automatic test_random(input int ready_pct, input int n);
        int gap;
        bit lvl;
        do_reset(); clear(1'b0);
        gap = $urandom_range(0, 5);
        lvl = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap == 0) begin
                gs[i] = 1'b1;
                gap = $urandom_range(0, G + 3);
            end else begin
                gap--;
            end
            if ($urandom_range(0, 3) == 0) lvl = !lvl;
            sp[i] = lvl;
            rdy[i] = ($urandom_range(0, 99) < ready_pct);
        end
        play(n);
        model(n);
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (ov_valid[i] !== e_valid[i] || ov_ovr[i] !== e_ovr[i] || ov_busy[i] !== e_busy[i]) begin
                n_bad++;
                $display("FAIL random_ctrl r%0d cyc %0d: got v%b o%b b%b want v%b o%b b%b",
                         ready_pct, i, ov_valid[i], ov_ovr[i], ov_busy[i], e_valid[i], e_ovr[i], e_busy[i]);
            end
            if (e_valid[i]) begin
                n_cmp++;
                if (ov_value[i] !== TW'(e_value[i]) || ov_none[i] !== e_none[i]) begin
                    n_bad++;
                    $display("FAIL random_value r%0d cyc %0d: got val%0d n%b want val%0d n%b",
                             ready_pct, i, ov_value[i], ov_none[i], e_value[i], e_none[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_spike();
        test_first_edge();
        test_overrun();
        test_early_restart();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random(80, 400);
        test_random(15, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_time_decoder.md
# spike_time_decoder

- Converts the temporal output of a race-logic stage, such as `less_than` in pulse-width mode, back into a binary value.
- Each gamma cycle is a window of `GAMMA_CYCLE_WIDTH` clocks. The block timestamps the first rising edge of `spike` inside the window and emits that timestamp once the window closes.
- If no edge arrives, it emits the "no spike" value `GAMMA_CYCLE_WIDTH`.
- It sits directly downstream of the comparator array and feeds binary consumers through a valid/ready handshake.

## Interface
- `GAMMA_CYCLE_WIDTH`, default 16: window length in clocks. Must be ≥ 2.
- `TW`, derived as `$clog2(GAMMA_CYCLE_WIDTH)+1`, not overridable: timestamp width.
- `aclk` in, 1: sole clock. All logic is on the rising edge.
- `grst` in, 1: reset, synchronous and active-low.
- `gamma_start` in, 1: single-cycle strobe. The cycle in which it is high is time 0 of a new window.
- `spike` in, 1: temporal input, a level pulse of any width.
- `t_value` out, TW: committed timestamp, 0..G-1, or G for no spike.
- `t_none` out, 1: set when the committed result is the no-spike value.
- `t_valid` out, 1: output slot holds a result.
- `t_ready` in, 1: consumer accepts the result. A transfer occurs when `t_valid & t_ready`.
- `overrun` out, 1: sticky. Set when a result was dropped because the slot was full.
- `busy` out, 1: a window is open.

## Operation
States:
- IDLE
  - `gamma_start` → COUNT with `tcnt=0`. That same cycle is evaluated as time 0.
- COUNT
  - `tcnt` increments each cycle.
  - The first detected edge latches `cap=tcnt` and sets `hit`. Later edges in the same window are ignored.
  - A window close fires in the cycle where `tcnt==G-1`, or when `gamma_start` arrives with `tcnt>0`.
    - The close commits `{hit ? cap : G}` to the output slot.
    - If `gamma_start` is high, a new window opens at time 0 in the same cycle, with `hit` cleared. Otherwise → IDLE.
- Edge detection:
  - An edge is `spike & ~spike_d`, where `spike_d` is a registered copy updated every cycle in all states.
  - A pulse that is already high when a window opens is not captured.
- Output slot (one entry):
  - A commit loads the slot when it is empty, or when it is being drained that same cycle.
  - Otherwise the new result is dropped and `overrun` is set.
  - A transfer with no commit clears `t_valid`.
- Arithmetic:
  - `tcnt` and `cap` are TW bits wide.
  - `tcnt` never exceeds G-1.
  - G is representable, so no wrap-around occurs.

## Timing
- Reset values: all outputs 0; state IDLE; `spike_d=0`; `hit=0`.
- Reset mid-window: the window is abandoned with no commit, and the slot contents are discarded.
- Commit latency:
  - For `gamma_start` at cycle c, the window covers c..c+G-1.
  - `t_valid` rises at c+G. Its value reflects every cycle of the window.
- Early restart: `gamma_start` at time k>0 commits the old window with k cycles observed. `t_valid` rises the next cycle.
- Simultaneous events in the closing cycle:
  - An edge in that cycle is included in the committed result.
  - A `gamma_start` in that cycle starts the next window without a gap.
- `t_value` and `t_none` are stable while `t_valid & ~t_ready`.
- `busy` is 1 from the cycle after `gamma_start` while in COUNT. It deasserts the cycle after a close with no restart.

## Configuration
- `SPIKE_GLITCH_FILTER_EN`
  - Defined: an edge at time t is accepted only if `spike` is still high at t+1 within the same window.
    - The recorded value is t.
    - An edge at t=G-1 is not accepted.
    - A pending edge at an early-restart close is discarded.
  - Undefined: a single high cycle following a low cycle is accepted immediately.

## Test plan
- G=16, `gamma_start` at cycle 10, `spike` rises at cycle 15 and stays high for 8 cycles, `t_ready=1` → `t_valid` for one cycle at cycle 26 with `t_value=5`, `t_none=0`.
- Window with `spike` held low throughout → `t_value=16`, `t_none=1` at start+16.
- Spike edges at times 3 and 9 in one window → committed value 3.
- `t_ready=0`, two consecutive windows with spikes at 2 and 7 → slot holds 2; the second commit is dropped and `overrun` becomes 1. Raising `t_ready` transfers 2, `t_valid` falls, and `overrun` stays 1.
- `gamma_start` at time 6 with no spike yet, then a spike at new-window time 1 → first commit is 16 one cycle later, second commit is 1.
- With `SPIKE_GLITCH_FILTER_EN`: one-cycle spike at time 4 and a two-cycle spike at time 8 → value 8. Without the macro → value 4.
- Reset (`grst=0`) asserted at window time 7 → next cycle all outputs 0 and state IDLE; no commit ever appears.
